// File: rtl/song_tone_sequencer_if.sv
// Player-side control inputs and tone/status outputs of the song tone sequencer.
interface song_tone_sequencer_if;
    logic       is_playing;
    logic [1:0] song;
    logic       tone;
    logic [2:0] note_idx;
    logic [2:0] note_code;
    logic       active;
    logic       song_end;

    modport master (
        output is_playing, song,
        input  tone, note_idx, note_code, active, song_end
    );

    modport slave (
        input  is_playing, song,
        output tone, note_idx, note_code, active, song_end
    );
endinterface

// File: rtl/song_tone_sequencer.sv
// Steps through a fixed 4x8 note table for the selected song and drives a square-wave tone.
// Pauses freeze position, a song change restarts at note 0, and each full pass pulses song_end.
module song_tone_sequencer #(
    parameter int unsigned NOTE_LEN  = 64,
    parameter int unsigned HALF_BASE = 4,
    parameter int unsigned HALF_STEP = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    song_tone_sequencer_if.slave  bus
);

    localparam int unsigned CNT_W = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PLAY  = 2'd1,
        PAUSE = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [1:0]         cur_song_q, cur_song_d;
    logic [2:0]         note_idx_q, note_idx_d;
    logic [2:0]         note_code_q, note_code_d;
    logic [CNT_W-1:0]   dur_cnt_q, dur_cnt_d;
    logic [CNT_W-1:0]   half_cnt_q, half_cnt_d;
    logic               tone_q, tone_d;
    logic               active_q, active_d;
    logic               song_end_q, song_end_d;

    // Note table, one row per song, index 7 in the leftmost slot.
    function automatic logic [2:0] note_lookup(input logic [1:0] s, input logic [2:0] i);
        logic [7:0][2:0] row;
        case (s)
            2'd0:    row = {3'd0, 3'd7, 3'd6, 3'd5, 3'd4, 3'd3, 3'd2, 3'd1};
            2'd1:    row = {3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7};
            2'd2:    row = {3'd0, 3'd1, 3'd3, 3'd5, 3'd7, 3'd5, 3'd3, 3'd1};
            default: row = {3'd7, 3'd7, 3'd0, 3'd4, 3'd4, 3'd0, 3'd4, 3'd4};
        endcase
        return row[i];
    endfunction

    // Higher codes give shorter half-periods, i.e. higher pitch.
    function automatic logic [CNT_W-1:0] half_len(input logic [2:0] k);
        return CNT_W'(HALF_BASE + (32'd8 - 32'(k)) * HALF_STEP);
    endfunction

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            cur_song_q  <= 2'd0;
            note_idx_q  <= 3'd0;
            note_code_q <= 3'd0;
            dur_cnt_q   <= '0;
            half_cnt_q  <= '0;
            tone_q      <= 1'b0;
            active_q    <= 1'b0;
            song_end_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            cur_song_q  <= cur_song_d;
            note_idx_q  <= note_idx_d;
            note_code_q <= note_code_d;
            dur_cnt_q   <= dur_cnt_d;
            half_cnt_q  <= half_cnt_d;
            tone_q      <= tone_d;
            active_q    <= active_d;
            song_end_q  <= song_end_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cur_song_d = cur_song_q;
        note_idx_d = note_idx_q;
        dur_cnt_d  = dur_cnt_q;
        half_cnt_d = half_cnt_q;
        tone_d     = tone_q;
        song_end_d = 1'b0;

        case (state_q)
            IDLE: begin
                tone_d = 1'b0;
                if (bus.is_playing) begin
                    state_d    = PLAY;
                    cur_song_d = bus.song;
                    note_idx_d = 3'd0;
                    dur_cnt_d  = '0;
                    half_cnt_d = '0;
                end
            end
            PLAY: begin
                if (!bus.is_playing) begin
                    state_d = PAUSE;
                    tone_d  = 1'b0;
                end else if (dur_cnt_q == CNT_W'(NOTE_LEN - 1)) begin
                    dur_cnt_d  = '0;
                    half_cnt_d = '0;
                    tone_d     = 1'b0;
                    note_idx_d = note_idx_q + 3'd1;
                    song_end_d = (note_idx_q == 3'd7);
                end else begin
                    dur_cnt_d = dur_cnt_q + CNT_W'(1);
                    if (note_code_q == 3'd0) begin
                        tone_d     = 1'b0;
                        half_cnt_d = '0;
                    end else if (half_cnt_q == half_len(note_code_q) - CNT_W'(1)) begin
                        tone_d     = ~tone_q;
                        half_cnt_d = '0;
                    end else begin
                        half_cnt_d = half_cnt_q + CNT_W'(1);
                    end
                end
            end
            PAUSE: begin
                tone_d = 1'b0;
                if (bus.is_playing) begin
                    state_d = PLAY;
                end
            end
            default: begin
                state_d = IDLE;
                tone_d  = 1'b0;
            end
        endcase

        // A new song selection restarts the pass and overrides any note advance or wrap.
        if (state_q != IDLE && bus.song != cur_song_q) begin
            cur_song_d = bus.song;
            note_idx_d = 3'd0;
            dur_cnt_d  = '0;
            half_cnt_d = '0;
            tone_d     = 1'b0;
            song_end_d = 1'b0;
        end

        note_code_d = (state_d == IDLE) ? 3'd0 : note_lookup(cur_song_d, note_idx_d);
        active_d    = (state_d == PLAY);
    end

    assign bus.tone      = tone_q;
    assign bus.note_idx  = note_idx_q;
    assign bus.note_code = note_code_q;
    assign bus.active    = active_q;
    assign bus.song_end  = song_end_q;

endmodule

// File: tb/tb_song_tone_sequencer.sv
// Directed bench for song_tone_sequencer: playback, pause/resume, song change, rests, async reset.
module tb_song_tone_sequencer;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    int tbl [4][8] = '{'{1, 2, 3, 4, 5, 6, 7, 0},
                       '{7, 6, 5, 4, 3, 2, 1, 0},
                       '{1, 3, 5, 7, 5, 3, 1, 0},
                       '{4, 4, 0, 4, 4, 0, 7, 7}};

    song_tone_sequencer_if bus ();

    song_tone_sequencer #(
        .NOTE_LEN (64),
        .HALF_BASE(4),
        .HALF_STEP(2)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    function automatic int exp_tone(input int code, input int m);
        int half;
        if (code == 0) return 0;
        half = 4 + (8 - code) * 2;
        return (m / half) % 2;
    endfunction

    // Observe n PLAY cycles of song s from uninterrupted play index p0 (0 = first cycle of the pass).
    task automatic play_cycles(input int s, input int p0, input int n);
        for (int i = 0; i < n; i++) begin
            int p;
            int idx;
            int m;
            p   = p0 + i;
            idx = (p / 64) % 8;
            m   = p % 64;
            check("active",    int'(bus.active),    1);
            check("note_idx",  int'(bus.note_idx),  idx);
            check("note_code", int'(bus.note_code), tbl[s][idx]);
            check("tone",      int'(bus.tone),      exp_tone(tbl[s][idx], m));
            check("song_end",  int'(bus.song_end),  (p > 0 && p % 512 == 0) ? 1 : 0);
            step();
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_tone"},      int'(bus.tone),      0);
        check({tag, "_note_idx"},  int'(bus.note_idx),  0);
        check({tag, "_note_code"}, int'(bus.note_code), 0);
        check({tag, "_active"},    int'(bus.active),    0);
        check({tag, "_song_end"},  int'(bus.song_end),  0);
    endtask

    initial begin
        checks         = 0;
        errors         = 0;
        rst            = 1'b0;
        bus.is_playing = 1'b0;
        bus.song       = 2'd0;

        step();
        step();
        check_all_zero("reset");
        rst = 1'b1;

        // Song input is ignored while idle.
        bus.song = 2'd3;
        for (int i = 0; i < 4; i++) begin
            step();
            check_all_zero("idle");
        end
        bus.song = 2'd0;
        step();

        // Song 0 from the start, through the wrap and song_end pulse.
        bus.is_playing = 1'b1;
        step();
        play_cycles(0, 0, 514);
        play_cycles(0, 514, 509);

        // Now at note 7, last cycle; change song on the boundary edge.
        check("pre_change_idx", int'(bus.note_idx), 7);
        bus.song = 2'd2;
        step();
        play_cycles(2, 0, 130);

        // Song 1: run into note 2 at dur 30, then pause.
        bus.song = 2'd1;
        step();
        play_cycles(1, 0, 158);
        bus.is_playing = 1'b0;
        for (int i = 0; i < 100; i++) begin
            step();
            check("pause_active",   int'(bus.active),    0);
            check("pause_tone",     int'(bus.tone),      0);
            check("pause_note_idx", int'(bus.note_idx),  2);
            check("pause_code",     int'(bus.note_code), 5);
            check("pause_song_end", int'(bus.song_end),  0);
        end
        bus.is_playing = 1'b1;
        step();
        // Resume at dur 30 with the half-period counter at 0; code 5 half-period is 10.
        for (int i = 0; i < 34; i++) begin
            check("resume_active", int'(bus.active),   1);
            check("resume_idx",    int'(bus.note_idx), 2);
            check("resume_tone",   int'(bus.tone),     (i / 10) % 2);
            step();
        end
        check("resume_idx_adv",  int'(bus.note_idx),  3);
        check("resume_code_adv", int'(bus.note_code), 4);
        check("resume_tone_adv", int'(bus.tone),      0);

        // Song 3: rests at index 2 and 5, fast code 7 at 6 and 7.
        bus.song = 2'd3;
        step();
        play_cycles(3, 0, 530);

        // Async reset mid-note while tone is high.
        check("pre_reset_tone", int'(bus.tone), 1);
        #2;
        rst = 1'b0;
        #1;
        check_all_zero("async_rst");
        step();
        step();
        check_all_zero("rst_hold");
        bus.is_playing = 1'b0;
        rst            = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            check_all_zero("post_rst_idle");
        end
        bus.is_playing = 1'b1;
        step();
        play_cycles(3, 0, 20);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/song_tone_sequencer.md
Name: song_tone_sequencer

Overview:
- Downstream consumer of the music player's `is_playing` and `song[1:0]` outputs.
- Holds a fixed 4-song x 8-note table and steps through the selected song's notes at a fixed note duration.
- Drives a square-wave `tone` output for a buzzer or speaker pin.
- Freezes on pause, restarts at note 0 on any song change, and flags the end of each pass through a song.

Parameters:
- NOTE_LEN, 64, clock cycles per note; legal range 2..65535.
- HALF_BASE, 4, base half-period in cycles.
- HALF_STEP, 2, half-period increment per note code step.

Ports:
- clk  input  1  system clock; all state on rising edge.
- rst  input  1  reset.
- is_playing  input  1  high = play, low = pause; from the music player.
- song  input  2  selected song 0..3; from the music player.
- tone  output  1  square-wave audio output.
- note_idx  output  3  position within the current song, 0..7.
- note_code  output  3  code of the current note; 0 = rest.
- active  output  1  high while in PLAY.
- song_end  output  1  one-cycle pulse on wrap from note 7 to note 0.

Interface: one clock; reset is asynchronous and active-low. `clk` is the clock and `rst` is the reset; `rst`=0 resets immediately, independent of `clk`.

Behaviour:
- Reset values: all outputs 0; state IDLE; `cur_song`=0; `dur_cnt`=0; `half_cnt`=0.
- Note table (note codes, index 0..7):
  - song0: 1,2,3,4,5,6,7,0
  - song1: 7,6,5,4,3,2,1,0
  - song2: 1,3,5,7,5,3,1,0
  - song3: 4,4,0,4,4,0,7,7
- `note_code` = table[`cur_song`][`note_idx`], registered.
- Half-period for code k (k≠0) = HALF_BASE + (8−k)*HALF_STEP. Defaults: code1=18, code7=6.
- Counters are 16 bits. Width overflow is impossible within the legal NOTE_LEN range.
- States:
  - IDLE: `tone`=0, `active`=0. When `is_playing`=1: go to PLAY, `cur_song`<=`song`, `note_idx`<=0, counters<=0.
  - PLAY:
    - `active`=1; `dur_cnt` increments every cycle.
    - When `dur_cnt`==NOTE_LEN−1: `dur_cnt`<=0, `half_cnt`<=0, `tone`<=0, and `note_idx` increments (7 wraps to 0).
    - On the 7→0 wrap, `song_end`=1 for exactly that next cycle. The song loops indefinitely.
    - Otherwise, if `note_code`≠0: `half_cnt` increments; when `half_cnt`==half−1, `tone` toggles and `half_cnt`<=0.
    - If `note_code`=0 (rest): `tone` held 0, `half_cnt` held 0.
    - When `is_playing`=0: go to PAUSE.
  - PAUSE:
    - `active`=0; `tone`<=0; `dur_cnt`, `half_cnt`, `note_idx` frozen.
    - When `is_playing`=1: return to PLAY. Counting resumes from the frozen values with `tone` starting at 0.
- Latency:
  - First PLAY cycle is the cycle after `is_playing` is first sampled high in IDLE.
  - `note_idx`=0 holds for exactly NOTE_LEN cycles of PLAY.
- Song change: `song`≠`cur_song` sampled in PLAY or PAUSE triggers a restart.
  - `cur_song`<=`song`, `note_idx`<=0, counters<=0, `tone`<=0; state unchanged.
  - Takes priority over note advance and over `song_end` in the same cycle; no `song_end` is produced.
  - Simultaneous song change and `is_playing` change: both apply (restart plus state transition).
- `song` is ignored in IDLE except when latched on IDLE→PLAY.
- Reset asserted mid-note returns everything to reset values immediately. No `song_end` is produced.
- There is no way back to IDLE except reset.

Test Plan:
- Reset, `song`=0, raise `is_playing` → `active`=1 next cycle; `tone` first rises 18 cycles after PLAY entry and toggles every 18 cycles; `note_idx`=1 after 64 cycles.
- Play song0 for 512 PLAY cycles → `note_idx` sequence 0..7; `song_end` single-cycle pulse at PLAY cycle 512; `tone`=0 throughout note 7 (rest).
- Song1, pause mid-note 2 at `dur_cnt`=30 for 100 cycles, then resume → `tone`=0 and `note_idx`=2 during the pause; `note_idx`=3 exactly 34 PLAY cycles after resume.
- In PLAY, change `song` 0→2 on the same cycle as the note-7 boundary → `note_idx`=0, `cur_song`=2, `note_code`=1, no `song_end` pulse.
- Song3 at note index 2 (code 0) → `tone` stays 0 for all 64 cycles; code 7 at index 6 toggles every 6 cycles.
- Assert `rst` low asynchronously mid-note in PLAY → all outputs 0 immediately; after release, stays IDLE until `is_playing`=1.
